// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - sweeps PUF challenges, majority-votes samples into a response word
//
// Purpose:
//   Steps a single-bit PUF through challenges 0..NUM_CHAL-1. For each challenge the
//   sequencer holds enable+challenge for SETTLE_CYCLES, takes VOTES synchronised
//   samples, and majority-votes them into resp_data[challenge]. A one-cycle GAP with
//   enable low re-arms the PUF between challenges. The finished word is offered on a
//   valid/ready handshake.
//
// Optional build macro:
//   PUF_SEQ_STABILITY_EN - when defined, unstable_mask[i] flags challenges whose
//   samples were not unanimous. When undefined, unstable_mask is tied to zero.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   start         in   request a full sweep (accepted only when idle)
//   abort         in   synchronous abort of a running sweep
//   busy          out  high from start-accept until back in idle
//   puf_enable    out  PUF enable
//   puf_challenge out  PUF challenge, CHAL_W bits
//   puf_response  in   PUF output, asynchronous to clk
//   resp_valid    out  response word available
//   resp_ready    in   consumer accepts the word
//   resp_data     out  voted bit per challenge, NUM_CHAL bits
//   unstable_mask out  per-challenge instability flags, NUM_CHAL bits

module puf_challenge_sequencer #(
    parameter int CHAL_W        = 2,
    parameter int NUM_CHAL      = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int VOTES         = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                puf_enable,
    output logic [CHAL_W-1:0]   puf_challenge,
    input  logic                puf_response,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [NUM_CHAL-1:0] resp_data,
    output logic [NUM_CHAL-1:0] unstable_mask
);

    if (VOTES % 2 == 0) begin : g_votes_even
        $error("puf_challenge_sequencer: VOTES must be odd");
    end
    if (NUM_CHAL > (1 << CHAL_W)) begin : g_num_chal_range
        $error("puf_challenge_sequencer: NUM_CHAL exceeds 2**CHAL_W");
    end
    if (SETTLE_CYCLES < 2) begin : g_settle_min
        $error("puf_challenge_sequencer: SETTLE_CYCLES must be at least 2");
    end

    localparam int CNT_MAX = (SETTLE_CYCLES > VOTES) ? SETTLE_CYCLES : VOTES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ONES_W  = $clog2(VOTES + 1);

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(VOTES - 1);
    localparam logic [CHAL_W-1:0] LAST_IDX    = CHAL_W'(NUM_CHAL - 1);
    localparam logic [ONES_W-1:0] HALF_VOTES  = ONES_W'(VOTES / 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic                sync1;
    logic                sync2;
    logic [CNT_W-1:0]    cnt;
    logic [ONES_W-1:0]   ones;
    logic [CHAL_W-1:0]   chal_idx;
    logic [NUM_CHAL-1:0] resp_q;

    // Ones count including the sample being taken this cycle; on the last SAMPLE
    // cycle this is the complete tally for the challenge.
    logic [ONES_W-1:0]   vote_total;
    logic                last_sample;
    logic                sweep_accept;
    logic                sweep_abort;

    assign vote_total   = ones + ONES_W'(sync2);
    assign last_sample  = (state == ST_SAMPLE) && (cnt == SAMPLE_LAST) && !abort;
    assign sweep_accept = (state == ST_IDLE) && start;
    assign sweep_abort  = abort && ((state == ST_SETTLE) || (state == ST_SAMPLE) ||
                                    (state == ST_GAP));

    // Outputs decode straight from state so the asynchronous reset clears them
    // without waiting for a clock edge.
    assign busy          = (state != ST_IDLE);
    assign puf_enable    = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign resp_valid    = (state == ST_DONE);
    assign puf_challenge = chal_idx;
    assign resp_data     = resp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (cnt == SETTLE_LAST) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (cnt == SAMPLE_LAST) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (chal_idx == LAST_IDX) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Two-flop synchroniser; only sync2 is ever sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= puf_response;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            ones     <= '0;
            chal_idx <= '0;
            resp_q   <= '0;
        end else if (sweep_accept) begin
            cnt      <= '0;
            ones     <= '0;
            chal_idx <= '0;
            resp_q   <= '0;
        end else if (sweep_abort) begin
            // The challenge bus keeps its last value; only the sweep results go.
            cnt    <= '0;
            ones   <= '0;
            resp_q <= '0;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (cnt == SAMPLE_LAST) begin
                        cnt              <= '0;
                        ones             <= '0;
                        resp_q[chal_idx] <= (vote_total > HALF_VOTES);
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        ones <= vote_total;
                    end
                end
                ST_GAP: begin
                    if (chal_idx != LAST_IDX) begin
                        chal_idx <= chal_idx + CHAL_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PUF_SEQ_STABILITY_EN
    logic [NUM_CHAL-1:0] unstable_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unstable_q <= '0;
        end else if (sweep_accept || sweep_abort) begin
            unstable_q <= '0;
        end else if (last_sample) begin
            unstable_q[chal_idx] <= (vote_total != '0) && (vote_total != ONES_W'(VOTES));
        end
    end

    assign unstable_mask = unstable_q;
`else
    logic unused_last_sample;

    assign unused_last_sample = last_sample;
    assign unstable_mask      = '0;
`endif

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb/tb_puf_challenge_sequencer.sv - randomized self-checking bench for puf_challenge_sequencer

module tb_puf_challenge_sequencer;

    localparam int CHAL_W        = 2;
    localparam int NUM_CHAL      = 4;
    localparam int SETTLE_CYCLES = 16;
    localparam int VOTES         = 5;
    localparam int LAT           = NUM_CHAL * (SETTLE_CYCLES + VOTES + 1);
    localparam int PAT_LEN       = SETTLE_CYCLES + VOTES;
    // The voted samples are the PUF outputs present during enable-cycles
    // WIN0..WIN0+VOTES-1 of a challenge: two synchroniser flops plus the
    // sampling register shift the SAMPLE window back by two cycles.
    localparam int WIN0          = SETTLE_CYCLES - 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                abort;
    logic                busy;
    logic                puf_enable;
    logic [CHAL_W-1:0]   puf_challenge;
    logic                puf_response;
    logic                resp_valid;
    logic                resp_ready;
    logic [NUM_CHAL-1:0] resp_data;
    logic [NUM_CHAL-1:0] unstable_mask;

    puf_challenge_sequencer #(
        .CHAL_W       (CHAL_W),
        .NUM_CHAL     (NUM_CHAL),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .VOTES        (VOTES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .puf_enable   (puf_enable),
        .puf_challenge(puf_challenge),
        .puf_response (puf_response),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .unstable_mask(unstable_mask)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // PUF model: each challenge plays a bit pattern indexed by cycles since enable rose.
    logic pat [NUM_CHAL][PAT_LEN];
    int   en_cnt = 0;

    always @(negedge clk) begin
        if (puf_enable) begin
            if (en_cnt < PAT_LEN) begin
                puf_response = pat[puf_challenge][en_cnt];
            end else begin
                puf_response = 1'b0;
            end
            en_cnt++;
        end else begin
            en_cnt       = 0;
            puf_response = 1'($urandom);
        end
    end

    task automatic set_fixed(input logic [NUM_CHAL-1:0] bits);
        for (int c = 0; c < NUM_CHAL; c++) begin
            for (int j = 0; j < PAT_LEN; j++) begin
                pat[c][j] = bits[c];
            end
        end
    endtask

    task automatic set_random();
        for (int c = 0; c < NUM_CHAL; c++) begin
            for (int j = 0; j < PAT_LEN; j++) begin
                pat[c][j] = 1'($urandom);
            end
        end
    endtask

    // Noisy challenge: random outside the voting window, given bits inside it.
    task automatic set_noisy(input int c, input logic [VOTES-1:0] w);
        for (int j = 0; j < PAT_LEN; j++) begin
            pat[c][j] = 1'($urandom);
        end
        for (int k = 0; k < VOTES; k++) begin
            pat[c][WIN0 + k] = w[k];
        end
    endtask

    function automatic void model(output logic [NUM_CHAL-1:0] d, output logic [NUM_CHAL-1:0] u);
        int ones;
        d = '0;
        u = '0;
        for (int c = 0; c < NUM_CHAL; c++) begin
            ones = 0;
            for (int k = 0; k < VOTES; k++) begin
                ones += int'(pat[c][WIN0 + k]);
            end
            d[c] = (ones > VOTES / 2);
            u[c] = (ones != 0) && (ones != VOTES);
        end
`ifndef PUF_SEQ_STABILITY_EN
        u = '0;
`endif
    endfunction

    logic [NUM_CHAL-1:0] last_data;
    logic [NUM_CHAL-1:0] last_mask;

    task automatic run_sweep(input string tag, input int hold, input bit poke);
        logic [NUM_CHAL-1:0] ed;
        logic [NUM_CHAL-1:0] eu;
        int                  n;
        bit                  stable;
        model(ed, eu);
        resp_ready = (hold == 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ":busy_on"}, 32'(busy), 32'd1);
        n = 0;
        while (!resp_valid && n < LAT + 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":latency"}, n, LAT);
        check({tag, ":data"}, 32'(resp_data), 32'(ed));
        check({tag, ":mask"}, 32'(unstable_mask), 32'(eu));
        last_data = resp_data;
        last_mask = unstable_mask;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            start = poke && (i < hold / 2) && (i % 3 == 0);
            abort = poke && (i < hold / 2);
            @(negedge clk);
            if (!(resp_valid === 1'b1 && resp_data === ed && unstable_mask === eu)) begin
                stable = 1'b0;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (hold > 0) begin
            check({tag, ":hold_stable"}, 32'(stable), 32'd1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check({tag, ":busy_off"}, 32'(busy), 32'd0);
        check({tag, ":valid_off"}, 32'(resp_valid), 32'd0);
        resp_ready = 1'b0;
        if (poke) begin
            repeat (5) @(negedge clk);
            check({tag, ":no_queued_start"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int  n;
        bit  seen_valid;
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        resp_ready   = 1'b0;
        puf_response = 1'b0;
        set_fixed('0);
        repeat (3) @(negedge clk);
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:enable", 32'(puf_enable), 32'd0);
        check("reset:valid", 32'(resp_valid), 32'd0);
        check("reset:challenge", 32'(puf_challenge), 32'd0);
        check("reset:data", 32'(resp_data), 32'd0);
        check("reset:mask", 32'(unstable_mask), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        set_fixed(4'b1101);
        run_sweep("fixed", 0, 1'b0);
        check("fixed:data_const", 32'(last_data), 32'h0000000d);

        set_fixed(4'b1101);
        set_noisy(2, 5'b10101);
        run_sweep("noisy_hi", 0, 1'b0);
        check("noisy_hi:data_const", 32'(last_data), 32'h0000000d);
`ifdef PUF_SEQ_STABILITY_EN
        check("noisy_hi:mask_const", 32'(last_mask), 32'h00000004);
`else
        check("noisy_hi:mask_const", 32'(last_mask), 32'h00000000);
`endif

        set_fixed(4'b1101);
        set_noisy(2, 5'b01010);
        run_sweep("noisy_lo", 0, 1'b0);
        check("noisy_lo:data_const", 32'(last_data), 32'h00000009);

        set_fixed(4'b0110);
        run_sweep("hold20", 20, 1'b1);

        // Abort during the SAMPLE phase of challenge 1.
        set_random();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE_CYCLES + VOTES + 1 + SETTLE_CYCLES + 2) @(negedge clk);
        check("abort:pre_challenge", 32'(puf_challenge), 32'd1);
        check("abort:pre_enable", 32'(puf_enable), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort:enable", 32'(puf_enable), 32'd0);
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:data", 32'(resp_data), 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen_valid = 1'b1;
        end
        check("abort:no_valid", 32'(seen_valid), 32'd0);
        set_fixed(4'b1011);
        run_sweep("after_abort", 2, 1'b0);

        // Asynchronous reset in the SETTLE phase of challenge 3.
        set_fixed(4'b1111);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 3 * (SETTLE_CYCLES + VOTES + 1) + 4;
        repeat (n) @(negedge clk);
        check("rst:pre_challenge", 32'(puf_challenge), 32'd3);
        rst = 1'b1;
        #1;
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:enable", 32'(puf_enable), 32'd0);
        check("rst:valid", 32'(resp_valid), 32'd0);
        check("rst:challenge", 32'(puf_challenge), 32'd0);
        check("rst:data", 32'(resp_data), 32'd0);
        check("rst:mask", 32'(unstable_mask), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_fixed(4'b0101);
        run_sweep("after_rst", 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            set_random();
            run_sweep($sformatf("rand%0d", r), int'($urandom_range(0, 6)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
- Sequences the single-bit PUF generator through a sweep of challenges.
- For each challenge: drives enable and the challenge, waits a settle period, and takes VOTES samples of the PUF output.
- Majority-votes the samples into one response bit per challenge and presents the assembled word to the key/ID logic over a valid/ready handshake.
- Sits between the root-of-trust key manager (requester) and the PUF generator instance.

Parameters:
- CHAL_W, 2, width of the PUF challenge bus.
- NUM_CHAL, 4, challenges swept (0..NUM_CHAL-1); must be ≤ 2**CHAL_W.
- SETTLE_CYCLES, 16, cycles enable+challenge are held before sampling; must be ≥ 2.
- VOTES, 5, samples per challenge; must be odd; elaboration error if even.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a full sweep; accepted only in IDLE.
- abort  input  1  synchronous abort of a running sweep.
- busy  output  1  high from start-accept until return to IDLE.
- puf_enable  output  1  drives the PUF enable.
- puf_challenge  output  CHAL_W  drives the PUF control/challenge input.
- puf_response  input  1  PUF output; asynchronous to clk.
- resp_valid  output  1  response word available.
- resp_ready  input  1  consumer accepts the word.
- resp_data  output  NUM_CHAL  resp_data[i] = voted bit for challenge i.
- unstable_mask  output  NUM_CHAL  per-challenge instability flags (see Optional Feature).

Behaviour:
- Reset (async, immediate): state=IDLE; busy, puf_enable, resp_valid = 0; puf_challenge, resp_data, unstable_mask, all counters = 0; synchroniser flops = 0.
- puf_response passes through a 2-flop synchroniser; only the synchronised value is sampled. SETTLE_CYCLES ≥ 2 covers the synchroniser delay.
- States: IDLE → SETTLE → SAMPLE → GAP → (SETTLE for next challenge | DONE) → IDLE.
- IDLE: puf_enable=0, busy=0. start=1 at an edge → SETTLE; challenge index=0; resp_data and unstable_mask cleared.
- SETTLE: puf_enable=1, puf_challenge=index. Stays exactly SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE: puf_enable=1. Exactly VOTES cycles; one synchronised sample per cycle added to a ones-counter of width clog2(VOTES+1).
- GAP: 1 cycle, puf_enable=0, so the PUF is re-armed between challenges.
  - On GAP entry: resp_data[index] = (ones > VOTES/2); ones-counter cleared.
  - If index == NUM_CHAL-1 → DONE; else index+1 → SETTLE.
- DONE: puf_enable=0, busy=1, resp_valid=1, resp_data stable. Leaves on resp_valid&&resp_ready → IDLE; busy falls the following cycle.
- Latency: resp_valid rises exactly NUM_CHAL*(SETTLE_CYCLES+VOTES+1) cycles after the start-accept edge (defaults: 88).
- start while busy (any non-IDLE state, including the DONE handshake cycle): ignored, not queued.
- abort=1 in SETTLE/SAMPLE/GAP → IDLE next cycle: puf_enable=0, resp_valid never asserted, resp_data cleared. abort in IDLE or DONE is ignored; DONE completes only via the handshake.
- abort and start together in IDLE: start wins.
- resp_valid never drops without resp_ready; resp_data is held for the whole valid period.
- puf_challenge holds its last value outside SETTLE/SAMPLE (0 after reset).

Optional Feature:
- Macro PUF_SEQ_STABILITY_EN.
- Defined: unstable_mask[i] is set on GAP entry when challenge i's samples were not unanimous (0 < ones < VOTES). It is cleared at start-accept and valid alongside resp_data.
- Undefined: unstable_mask is tied to 0 and no extra logic is built. Port list is identical either way.

Test Plan:
- PUF model returns fixed bit per challenge {c0=1,c1=0,c2=1,c3=1}, start pulse, resp_ready=1 → resp_valid exactly 88 cycles after accept, resp_data=4'b1101, busy low one cycle after handshake.
- Challenge 2 model outputs 1,0,1,0,1 across SAMPLE cycles → resp_data[2]=1. With 0,1,0,1,0 → resp_data[2]=0.
- resp_ready held 0 for 20 cycles after resp_valid → resp_valid/resp_data stable throughout. Start pulses during this window are ignored; one sweep only.
- abort asserted during challenge 1 SAMPLE → puf_enable=0 next cycle, IDLE, no resp_valid. A new start then produces a full 88-cycle sweep.
- rst asserted mid-SETTLE of challenge 3 → all outputs 0 immediately (asynchronous, before the next clk edge); after rst release, a new start works normally.
- With PUF_SEQ_STABILITY_EN: the noisy-challenge-2 case gives unstable_mask=4'b0100, stable cases give 0. Without the macro, unstable_mask=0 in all cases.
